sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/id_fifo.sv | 54 +++++
 rtl/sram_like_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared bus defaults, arbitration mode encodings and arbiter state type
package cpu_bus_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

endpackage

// File: rtl/id_fifo.sv
// rtl/id_fifo.sv - in-order synchronous FIFO of channel IDs for outstanding transactions
module id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-to-1 SRAM-like bus arbiter with in-order response routing
module sram_like_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_OUT  = 4,
   parameter int ARB_MODE = ARB_FIXED
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [NUM_CH-1:0]            s_req,
   input  logic [NUM_CH-1:0]            s_wr,
   input  logic [NUM_CH*DATA_W/8-1:0]   s_wstrb,
   input  logic [NUM_CH*ADDR_W-1:0]     s_addr,
   input  logic [NUM_CH*DATA_W-1:0]     s_wdata,
   output logic [NUM_CH-1:0]            s_addr_ok,
   output logic [NUM_CH-1:0]            s_data_ok,
   output logic [DATA_W-1:0]            s_rdata,
   output logic                         m_req,
   output logic                         m_wr,
   output logic [DATA_W/8-1:0]          m_wstrb,
   output logic [ADDR_W-1:0]            m_addr,
   output logic [DATA_W-1:0]            m_wdata,
   input  logic                         m_addr_ok,
   input  logic                         m_data_ok,
   input  logic [DATA_W-1:0]            m_rdata,
   output logic                         err_spurious
);

   localparam int STRB_W = DATA_W / 8;
   localparam int ID_W   = $clog2(NUM_CH);

   arb_state_t      state;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] cur_ch;
   logic [ID_W-1:0] head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            req_int;
   logic            handshake;
   logic            pop;
   logic            found;
   int              base;

   // Fixed priority is a round-robin search pinned to start at channel 0
   always_comb begin
      base   = (ARB_MODE == ARB_RR) ? int'(rr_ptr) : 0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && s_req[(base + i) % NUM_CH]) begin
            winner = ID_W'((base + i) % NUM_CH);
            found  = 1'b1;
         end
      end
   end

   assign cur_ch    = (state == ARB_HOLD) ? grant : winner;
   assign req_int   = resetn & ((state == ARB_HOLD) | ((|s_req) & ~fifo_full));
   assign handshake = req_int & m_addr_ok;
   assign pop       = resetn & m_data_ok & ~fifo_empty;

   assign m_req   = req_int;
   assign m_wr    = resetn & s_wr[cur_ch];
   assign m_wstrb = resetn ? s_wstrb[int'(cur_ch)*STRB_W +: STRB_W] : '0;
   assign m_addr  = resetn ? s_addr[int'(cur_ch)*ADDR_W +: ADDR_W] : '0;
   assign m_wdata = resetn ? s_wdata[int'(cur_ch)*DATA_W +: DATA_W] : '0;
   assign s_rdata = resetn ? m_rdata : '0;

   always_comb begin
      s_addr_ok = '0;
      s_data_ok = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         s_addr_ok[i] = handshake & (cur_ch == ID_W'(i));
         s_data_ok[i] = pop & (head == ID_W'(i));
      end
   end

   id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUT)
   ) u_id_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (handshake),
      .push_data (cur_ch),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ARB_IDLE;
         grant        <= '0;
         rr_ptr       <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (m_data_ok && fifo_empty) begin
            err_spurious <= 1'b1;
         end
         if (handshake) begin
            rr_ptr <= (cur_ch == ID_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
         end
         // HOLD is only reachable when not full, so the held request always fits
         case (state)
            ARB_IDLE: begin
               if (req_int && !m_addr_ok) begin
                  state <= ARB_HOLD;
                  grant <= winner;
               end
            end
            ARB_HOLD: begin
               if (m_addr_ok) begin
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;

   logic clk = 1'b0;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // Fixed-priority instance, two channels
   logic [1:0]  f_s_req, f_s_wr, f_s_addr_ok, f_s_data_ok;
   logic [7:0]  f_s_wstrb;
   logic [63:0] f_s_addr, f_s_wdata;
   logic [31:0] f_s_rdata, f_m_addr, f_m_wdata, f_m_rdata;
   logic [3:0]  f_m_wstrb;
   logic        f_m_req, f_m_wr, f_m_addr_ok, f_m_data_ok, f_err;

   // Round-robin instance, four channels
   logic [3:0]   r_s_req, r_s_wr, r_s_addr_ok, r_s_data_ok;
   logic [15:0]  r_s_wstrb;
   logic [127:0] r_s_addr, r_s_wdata;
   logic [31:0]  r_s_rdata, r_m_addr, r_m_wdata, r_m_rdata;
   logic [3:0]   r_m_wstrb;
   logic         r_m_req, r_m_wr, r_m_addr_ok, r_m_data_ok, r_err;

   logic [3:0]   exp4;

   sram_like_arbiter #(.NUM_CH(2), .MAX_OUT(4), .ARB_MODE(0)) dut_fix (
      .clk (clk), .resetn (resetn),
      .s_req (f_s_req), .s_wr (f_s_wr), .s_wstrb (f_s_wstrb), .s_addr (f_s_addr),
      .s_wdata (f_s_wdata), .s_addr_ok (f_s_addr_ok), .s_data_ok (f_s_data_ok),
      .s_rdata (f_s_rdata), .m_req (f_m_req), .m_wr (f_m_wr), .m_wstrb (f_m_wstrb),
      .m_addr (f_m_addr), .m_wdata (f_m_wdata), .m_addr_ok (f_m_addr_ok),
      .m_data_ok (f_m_data_ok), .m_rdata (f_m_rdata), .err_spurious (f_err)
   );

   sram_like_arbiter #(.NUM_CH(4), .MAX_OUT(4), .ARB_MODE(1)) dut_rr (
      .clk (clk), .resetn (resetn),
      .s_req (r_s_req), .s_wr (r_s_wr), .s_wstrb (r_s_wstrb), .s_addr (r_s_addr),
      .s_wdata (r_s_wdata), .s_addr_ok (r_s_addr_ok), .s_data_ok (r_s_data_ok),
      .s_rdata (r_s_rdata), .m_req (r_m_req), .m_wr (r_m_wr), .m_wstrb (r_m_wstrb),
      .m_addr (r_m_addr), .m_wdata (r_m_wdata), .m_addr_ok (r_m_addr_ok),
      .m_data_ok (r_m_data_ok), .m_rdata (r_m_rdata), .err_spurious (r_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn      = 1'b0;
      f_s_req     = 2'b11;  f_s_wr = '0; f_s_wstrb = '0;
      f_s_addr    = {32'h0000_0200, 32'h0000_0100};
      f_s_wdata   = '0;     f_m_addr_ok = 1'b1; f_m_data_ok = 1'b1;
      f_m_rdata   = 32'h1234_5678;
      r_s_req     = 4'hF;   r_s_wr = '0; r_s_wstrb = '0; r_s_addr = '0; r_s_wdata = '0;
      r_m_addr_ok = 1'b1;   r_m_data_ok = 1'b1; r_m_rdata = 32'h8765_4321;
      tick();
      tick();

      // Outputs forced low while reset is held, despite active inputs
      check("rst_m_req",     64'(f_m_req),     64'd0);
      check("rst_s_addr_ok", 64'(f_s_addr_ok), 64'd0);
      check("rst_s_data_ok", 64'(f_s_data_ok), 64'd0);
      check("rst_s_rdata",   64'(f_s_rdata),   64'd0);
      check("rst_m_addr",    64'(f_m_addr),    64'd0);
      check("rst_err",       64'(f_err),       64'd0);
      check("rst_rr_m_req",  64'(r_m_req),     64'd0);

      resetn = 1'b1;
      f_s_req = '0; f_m_addr_ok = 1'b0; f_m_data_ok = 1'b0;
      r_s_req = '0; r_m_addr_ok = 1'b0; r_m_data_ok = 1'b0;
      tick();

      // Round-robin: eight handshakes with a pop each cycle after the first
      r_s_req = 4'hF; r_m_addr_ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         r_m_data_ok = (k > 0);
         r_m_rdata   = 32'h5000 + 32'(k);
         #1;
         exp4 = 4'b0001 << (k % 4);
         check("rr_grant", 64'(r_s_addr_ok), 64'(exp4));
         if (k > 0) begin
            exp4 = 4'b0001 << ((k - 1) % 4);
            check("rr_data_ok", 64'(r_s_data_ok), 64'(exp4));
            check("rr_rdata",   64'(r_s_rdata),   64'h5000 + 64'(k));
         end
         tick();
      end
      r_s_req = '0; r_m_addr_ok = 1'b0; r_m_data_ok = 1'b1;
      #1;
      check("rr_last_data_ok", 64'(r_s_data_ok), 64'b1000);
      check("rr_idle_m_req",   64'(r_m_req),     64'd0);
      tick();
      r_m_data_ok = 1'b0;

      // Fixed priority: both request, ch0 first then ch1 (a write)
      f_s_req   = 2'b11;
      f_s_addr  = {32'h0000_0200, 32'h0000_0100};
      f_s_wr    = 2'b10;
      f_s_wstrb = {4'hC, 4'hF};
      f_s_wdata = {32'hDEAD_BEEF, 32'h0};
      f_m_addr_ok = 1'b1;
      #1;
      check("fix_c0_addr_ok", 64'(f_s_addr_ok), 64'b01);
      check("fix_c0_m_addr",  64'(f_m_addr),    64'h100);
      check("fix_c0_m_wr",    64'(f_m_wr),      64'd0);
      tick();
      f_s_req = 2'b10;
      #1;
      check("fix_c1_addr_ok", 64'(f_s_addr_ok), 64'b10);
      check("fix_c1_m_addr",  64'(f_m_addr),    64'h200);
      check("fix_c1_m_wr",    64'(f_m_wr),      64'd1);
      check("fix_c1_m_wstrb", 64'(f_m_wstrb),   64'hC);
      check("fix_c1_m_wdata", 64'(f_m_wdata),   64'hDEAD_BEEF);
      tick();

      f_s_req = '0; f_s_wr = '0; f_m_addr_ok = 1'b0;
      f_m_data_ok = 1'b1; f_m_rdata = 32'hAAAA_0001;
      #1;
      check("fix_rsp0_data_ok", 64'(f_s_data_ok), 64'b01);
      check("fix_rsp0_rdata",   64'(f_s_rdata),   64'hAAAA_0001);
      check("fix_rsp0_m_req",   64'(f_m_req),     64'd0);
      tick();
      f_m_rdata = 32'hAAAA_0002;
      #1;
      check("fix_rsp1_data_ok", 64'(f_s_data_ok), 64'b10);
      tick();
      f_m_data_ok = 1'b0;

      // HOLD: ch1 stalled, ch0 arrives later and must wait
      f_s_req  = 2'b10;
      f_s_addr = {32'h0000_0300, 32'h0000_0104};
      #1;
      check("hold_m_req",   64'(f_m_req),     64'd1);
      check("hold_addr_ok", 64'(f_s_addr_ok), 64'b00);
      check("hold_m_addr",  64'(f_m_addr),    64'h300);
      tick();
      f_s_req = 2'b11;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("hold_keep_m_addr",  64'(f_m_addr),    64'h300);
         check("hold_keep_addr_ok", 64'(f_s_addr_ok), 64'b00);
         tick();
      end
      f_m_addr_ok = 1'b1;
      #1;
      check("hold_accept_c1", 64'(f_s_addr_ok), 64'b10);
      check("hold_accept_m_addr", 64'(f_m_addr), 64'h300);
      tick();
      f_s_req = 2'b01;
      #1;
      check("hold_next_c0",   64'(f_s_addr_ok), 64'b01);
      check("hold_next_addr", 64'(f_m_addr),    64'h104);
      tick();

      // Third read from ch1, then in-order responses A,B,C
      f_s_req = 2'b10;
      #1;
      check("ord_push_c1", 64'(f_s_addr_ok), 64'b10);
      tick();
      f_s_req = '0; f_m_addr_ok = 1'b0; f_m_data_ok = 1'b1;
      f_m_rdata = 32'h0000_000A;
      #1;
      check("ord_a_data_ok", 64'(f_s_data_ok), 64'b10);
      check("ord_a_rdata",   64'(f_s_rdata),   64'hA);
      tick();
      f_m_rdata = 32'h0000_000B;
      #1;
      check("ord_b_data_ok", 64'(f_s_data_ok), 64'b01);
      check("ord_b_rdata",   64'(f_s_rdata),   64'hB);
      tick();
      f_m_rdata = 32'h0000_000C;
      #1;
      check("ord_c_data_ok", 64'(f_s_data_ok), 64'b10);
      check("ord_c_rdata",   64'(f_s_rdata),   64'hC);
      tick();
      f_m_data_ok = 1'b0;

      // Full: four accepted, fifth blocked even with a pop in the same cycle
      f_s_req = 2'b01; f_m_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("full_fill_addr_ok", 64'(f_s_addr_ok), 64'b01);
         tick();
      end
      f_m_data_ok = 1'b1;
      #1;
      check("full_m_req",     64'(f_m_req),     64'd0);
      check("full_addr_ok",   64'(f_s_addr_ok), 64'b00);
      check("full_pop_ok",    64'(f_s_data_ok), 64'b01);
      tick();
      f_m_data_ok = 1'b0;
      #1;
      check("full_reopen_m_req",   64'(f_m_req),     64'd1);
      check("full_reopen_addr_ok", 64'(f_s_addr_ok), 64'b01);
      tick();
      f_s_req = '0; f_m_addr_ok = 1'b0; f_m_data_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_data_ok", 64'(f_s_data_ok), 64'b01);
         tick();
      end

      // Spurious response while empty
      #1;
      check("spur_no_data_ok", 64'(f_s_data_ok), 64'b00);
      check("spur_err_before", 64'(f_err),       64'd0);
      tick();
      f_m_data_ok = 1'b0;
      #1;
      check("spur_err_set", 64'(f_err), 64'd1);
      tick();
      check("spur_err_sticky", 64'(f_err), 64'd1);

      // Reset with two reads outstanding discards them
      f_s_req = 2'b01; f_m_addr_ok = 1'b1;
      tick();
      tick();
      f_s_req = '0; f_m_addr_ok = 1'b0;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      f_m_data_ok = 1'b1;
      #1;
      check("rst_err_clear",    64'(f_err),       64'd0);
      check("rst_fifo_cleared", 64'(f_s_data_ok), 64'b00);
      tick();
      f_m_data_ok = 1'b0;
      #1;
      check("rst_then_spur_err", 64'(f_err), 64'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
